// File: rtl/vga_timing_ctrl_p.sv
// Parametrised VGA timing generator with pixel request port and per-frame test patterns.
// Pipeline: stage0 counters, stage1 request/coords, stage2 host data, stage3 DAC outputs.
module vga_timing_ctrl_p #(
    parameter int COLOR_W  = 4,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int SYNC_POL = 0,
    parameter int CNT_W    = 11
) (
    input  logic               iVGA_CLK,
    input  logic               iRST_n,
    input  logic [1:0]         iMode,
    input  logic [COLOR_W-1:0] iRed,
    input  logic [COLOR_W-1:0] iGreen,
    input  logic [COLOR_W-1:0] iBlue,
    output logic               oRequest,
    output logic [CNT_W-1:0]   oX,
    output logic [CNT_W-1:0]   oY,
    output logic               oFrameStart,
    output logic [COLOR_W-1:0] oVGA_R,
    output logic [COLOR_W-1:0] oVGA_G,
    output logic [COLOR_W-1:0] oVGA_B,
    output logic               oVGA_H_SYNC,
    output logic               oVGA_V_SYNC,
    output logic               oVGA_BLANK_n
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CNT_W-1:0] X_LAST = CNT_W'(H_ACTIVE - 1);
    localparam logic [CNT_W-1:0] Y_LAST = CNT_W'(V_ACTIVE - 1);
    localparam logic             SP     = (SYNC_POL != 0);

    logic [CNT_W-1:0] r_h, r_v;
    logic [1:0]       r_mode;
    logic             w_h_wrap;
    logic [2:0]       w_flg0;

    assign w_h_wrap = (r_h == H_LAST);
    // Flags are {visible, hsync, vsync}, carried through the pipe as active-high
    assign w_flg0 = {(r_h < H_ACT) && (r_v < V_ACT),
                     (r_h >= HS_BEG) && (r_h < HS_END),
                     (r_v >= VS_BEG) && (r_v < VS_END)};

    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            r_h    <= '0;
            r_v    <= '0;
            r_mode <= '0;
        end else begin
            if (w_h_wrap) begin
                r_h <= '0;
                r_v <= (r_v == V_LAST) ? '0 : r_v + 1'b1;
            end else begin
                r_h <= r_h + 1'b1;
            end
            if (w_h_wrap && (r_v == V_LAST))
                r_mode <= iMode;
        end
    end

    logic [3:1][2:0]  r_flg_pipe;
    logic [CNT_W-1:0] r_x, r_y;
    logic             r_req, r_fs;
    logic [1:0]       r_mode1, r_mode2;
    logic [2:0]       r_pat2;
    logic [COLOR_W-1:0] r_r, r_g, r_b;

    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            r_flg_pipe <= '0;
            r_x        <= '0;
            r_y        <= '0;
            r_req      <= 1'b0;
            r_fs       <= 1'b0;
            r_mode1    <= '0;
        end else begin
            r_flg_pipe <= {r_flg_pipe[2:1], w_flg0};
            r_x        <= r_h;
            r_y        <= r_v;
            r_req      <= w_flg0[2] && (r_mode == 2'd0);
            r_fs       <= (r_h == '0) && (r_v == '0);
            r_mode1    <= r_mode;
        end
    end

    // Bar index = x*8/H_ACTIVE, found by counting passed thresholds ceil(k*H_ACTIVE/8)
    logic [2:0] w_bar;
    logic       w_grid;
    logic [2:0] w_pat;

    always_comb begin
        w_bar = '0;
        for (int k = 1; k < 8; k++)
            if (r_x >= CNT_W'((k * H_ACTIVE + 7) / 8))
                w_bar = w_bar + 3'd1;
        w_grid = (r_x[4:0] == 5'd0) || (r_y[4:0] == 5'd0) || (r_x == X_LAST) || (r_y == Y_LAST);
        case (r_mode1)
            2'd1:    w_pat = {~w_bar[1], ~w_bar[2], ~w_bar[0]};
            2'd2:    w_pat = {3{w_grid}};
            default: w_pat = '0;
        endcase
    end

    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            r_mode2 <= '0;
            r_pat2  <= '0;
            r_r     <= '0;
            r_g     <= '0;
            r_b     <= '0;
        end else begin
            r_mode2 <= r_mode1;
            r_pat2  <= w_pat;
            if (!r_flg_pipe[2][2]) begin
                r_r <= '0;
                r_g <= '0;
                r_b <= '0;
            end else if (r_mode2 == 2'd0) begin
                r_r <= iRed;
                r_g <= iGreen;
                r_b <= iBlue;
            end else begin
                r_r <= {COLOR_W{r_pat2[2]}};
                r_g <= {COLOR_W{r_pat2[1]}};
                r_b <= {COLOR_W{r_pat2[0]}};
            end
        end
    end

    assign oRequest     = r_req;
    assign oX           = r_x;
    assign oY           = r_y;
    assign oFrameStart  = r_fs;
    assign oVGA_R       = r_r;
    assign oVGA_G       = r_g;
    assign oVGA_B       = r_b;
    assign oVGA_BLANK_n = r_flg_pipe[3][2];
    assign oVGA_H_SYNC  = r_flg_pipe[3][1] ? SP : ~SP;
    assign oVGA_V_SYNC  = r_flg_pipe[3][0] ? SP : ~SP;
endmodule

// File: tb/tb_vga_timing_ctrl_p.sv
// Randomized scoreboard bench for vga_timing_ctrl_p using a small raster so whole frames fit.
module tb_vga_timing_ctrl_p;
    localparam int CW = 4, NW = 11;
    localparam int HA = 100, HFP = 4, HS = 10, HBP = 6;
    localparam int VA = 36, VFP = 2, VS = 3, VBP = 2;
    localparam bit SP = 1'b0;
    localparam int HT = HA + HFP + HS + HBP;
    localparam int VT = VA + VFP + VS + VBP;
    localparam int FT = HT * VT;

    logic clk = 1'b0, rst_n = 1'b0;
    logic [1:0] mode = 2'd0;
    logic [CW-1:0] hr = '0, hg = '0, hb = '0;
    logic req, fs, hsync, vsync, blank_n;
    logic [NW-1:0] ox, oy;
    logic [CW-1:0] vr, vg, vb;

    vga_timing_ctrl_p #(.COLOR_W(CW), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP), .SYNC_POL(0), .CNT_W(NW)) dut (
        .iVGA_CLK(clk), .iRST_n(rst_n), .iMode(mode), .iRed(hr), .iGreen(hg), .iBlue(hb),
        .oRequest(req), .oX(ox), .oY(oy), .oFrameStart(fs),
        .oVGA_R(vr), .oVGA_G(vg), .oVGA_B(vb),
        .oVGA_H_SYNC(hsync), .oVGA_V_SYNC(vsync), .oVGA_BLANK_n(blank_n));

    always #5 clk = ~clk;

    typedef struct packed { logic req; logic fs; logic [NW-1:0] x; logic [NW-1:0] y; } s1_t;
    typedef struct packed { logic blank; logic hs; logic vs; logic [CW-1:0] r; logic [CW-1:0] g; logic [CW-1:0] b; } s3_t;
    typedef struct packed { logic [CW-1:0] r; logic [CW-1:0] g; logic [CW-1:0] b; } rgb_t;

    s1_t  q1[$];
    s3_t  q3[$];
    rgb_t hq[$];
    int   checks = 0, errors = 0;
    bit   run = 1'b0;
    int   cyc = 0;
    int   fmode[0:63];
    bit   req_last = 1'b0;
    int   plan[8] = '{2, 1, 0, 3, 0, 2, 1, 0};
    logic [7:0] r_on = 8'b00110011;   // bar order: white yellow cyan green magenta red blue black
    logic [7:0] g_on = 8'b00001111;
    logic [7:0] b_on = 8'b01010101;
    rgb_t hc;
    s1_t  e1, a1;
    s3_t  e3, a3;

    function automatic s3_t idle3();
        s3_t s;
        s = '0;
        s.hs = ~SP;
        s.vs = ~SP;
        return s;
    endfunction

    // Expected behaviour of raster position n (clocks since reset release)
    task automatic push_pixel(input int n);
        int f, r, h, v, m, bar;
        bit vis, hsy, vsy;
        s1_t x1;
        s3_t x3;
        rgb_t c;
        f = n / FT; r = n % FT; h = r % HT; v = r / HT; m = fmode[f];
        vis = (h < HA) && (v < VA);
        hsy = (h >= HA + HFP) && (h < HA + HFP + HS);
        vsy = (v >= VA + VFP) && (v < VA + VFP + VS);
        x1.req = vis && (m == 0);
        x1.fs  = (r == 0);
        x1.x   = NW'(h);
        x1.y   = NW'(v);
        x3 = '0;
        x3.blank = vis;
        x3.hs = hsy ? SP : ~SP;
        x3.vs = vsy ? SP : ~SP;
        if (vis) begin
            case (m)
                0: begin
                    c.r = CW'($urandom); c.g = CW'($urandom); c.b = CW'($urandom);
                    hq.push_back(c);
                    x3.r = c.r; x3.g = c.g; x3.b = c.b;
                end
                1: begin
                    bar = h * 8 / HA;
                    x3.r = r_on[bar] ? '1 : '0;
                    x3.g = g_on[bar] ? '1 : '0;
                    x3.b = b_on[bar] ? '1 : '0;
                end
                2: if ((h % 32 == 0) || (v % 32 == 0) || (h == HA - 1) || (v == VA - 1)) begin
                    x3.r = '1; x3.g = '1; x3.b = '1;
                end
                default: ;
            endcase
        end
        q1.push_back(x1);
        q3.push_back(x3);
    endtask

    task automatic check_idle(input string tag);
        checks++;
        if ({req, fs, ox, oy, vr, vg, vb, blank_n} !== '0 || hsync !== ~SP || vsync !== ~SP) begin
            errors++;
            $display("FAIL %s got req=%b fs=%b x=%0d y=%0d rgb=%h%h%h blank_n=%b hs=%b vs=%b want all 0, syncs %b",
                     tag, req, fs, ox, oy, vr, vg, vb, blank_n, hsync, vsync, ~SP);
        end
    endtask

    task automatic start_run();
        q1.delete(); q3.delete(); hq.delete();
        q3.push_back(idle3());
        q3.push_back(idle3());
        fmode[0] = 0;
        cyc = 0;
        req_last = 1'b0;
        rst_n = 1'b1;
        push_pixel(0);
        run = 1'b1;
    endtask

    // Stimulus: host responder, frame-mode schedule, expected-value generation
    always @(posedge clk) begin
        #1;
        if (run) begin
            cyc++;
            if (req_last) begin
                if (hq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL host_queue cyc=%0d got request with no expected pixel want none", cyc);
                end else begin
                    hc = hq.pop_front();
                    hr = hc.r; hg = hc.g; hb = hc.b;
                end
            end else begin
                hr = CW'($urandom); hg = CW'($urandom); hb = CW'($urandom);
            end
            req_last = req;
            if (cyc % FT == FT / 2)
                mode = 2'(plan[(cyc / FT) % 8]);
            else if ((cyc % FT < FT / 3) && ($urandom_range(0, 299) == 0))
                mode = 2'($urandom_range(0, 3));
            if (cyc % FT == FT - 1)
                fmode[cyc / FT + 1] = int'(mode);
            push_pixel(cyc);
        end
    end

    // Monitor: one request-stage and one DAC-stage observation per clock
    always @(posedge clk) begin
        #1;
        if (run) begin
            if (q1.size() == 0 || q3.size() == 0) begin
                checks++; errors++;
                $display("FAIL scoreboard_empty cyc=%0d got no expected entry want one", cyc);
            end else begin
                e1 = q1.pop_front();
                a1 = {req, fs, ox, oy};
                checks++;
                if (a1 !== e1) begin
                    errors++;
                    $display("FAIL stage1 cyc=%0d got req=%b fs=%b x=%0d y=%0d want req=%b fs=%b x=%0d y=%0d",
                             cyc, a1.req, a1.fs, a1.x, a1.y, e1.req, e1.fs, e1.x, e1.y);
                end
                e3 = q3.pop_front();
                a3 = {blank_n, hsync, vsync, vr, vg, vb};
                checks++;
                if (a3 !== e3) begin
                    errors++;
                    $display("FAIL dac cyc=%0d got blank_n=%b hs=%b vs=%b rgb=%h%h%h want blank_n=%b hs=%b vs=%b rgb=%h%h%h",
                             cyc, a3.blank, a3.hs, a3.vs, a3.r, a3.g, a3.b, e3.blank, e3.hs, e3.vs, e3.r, e3.g, e3.b);
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_idle("reset_hold");
        start_run();
        repeat (FT * 5 + 1234) @(negedge clk);
        run = 1'b0;
        rst_n = 1'b0;
        #1;
        check_idle("reset_midline_async");
        repeat (2) @(negedge clk);
        check_idle("reset_midline_hold");
        start_run();
        repeat (FT + 300) @(negedge clk);
        run = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
